// File: rtl/button_conditioner.sv
// Synchronizes, debounces and edge-detects three pushbuttons into single-cycle press pulses.
// Optional auto-repeat for left/right is enabled by defining BUTTON_AUTO_REPEAT_EN.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 10000000
) (
  input  logic clk,
  input  logic rst,
  input  logic left_raw,
  input  logic right_raw,
  input  logic put_raw,
  output logic left,
  output logic right,
  output logic put
);

  localparam int MAX_AB = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAXP   = (MAX_AB > REPEAT_PERIOD) ? MAX_AB : REPEAT_PERIOD;
  localparam int CW     = $clog2(MAXP) + 1;

  // bit 0 = left, bit 1 = right, bit 2 = put
  logic [2:0]    raw_s;
  logic [2:0]    sync1_q;
  logic [2:0]    sync2_q;
  logic [2:0]    stable_q;
  logic [2:0]    stable_d;
  logic [2:0]    stable_prev_q;
  logic [CW-1:0] cnt_q [3];
  logic [CW-1:0] cnt_d [3];
  logic [2:0]    rise_s;
  logic [1:0]    rep_fire_s;
  logic [2:0]    ev_s;
  logic          left_q, right_q, put_q;
  logic          left_d, right_d, put_d;

  assign raw_s  = {put_raw, right_raw, left_raw};
  assign rise_s = stable_q & ~stable_prev_q;

  // Mismatch counting: flip the debounced level once the synchronized value has disagreed long enough
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      stable_d[i] = stable_q[i];
      cnt_d[i]    = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (cnt_q[i] >= CW'(DEBOUNCE_CYCLES - 1)) begin
          stable_d[i] = ~stable_q[i];
          cnt_d[i]    = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CW'(1);
        end
      end else begin
        cnt_d[i] = '0;
      end
    end
  end

  // Synchronizers, debounced levels and mismatch counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= 3'b000;
      sync2_q       <= 3'b000;
      stable_q      <= 3'b000;
      stable_prev_q <= 3'b000;
      for (int i = 0; i < 3; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q       <= raw_s;
      sync2_q       <= sync1_q;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
      for (int i = 0; i < 3; i++) cnt_q[i] <= cnt_d[i];
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  // Timer value N means N edges have passed since the last pulse; zero means idle.
  logic [CW-1:0] rep_cnt_q [2];
  logic [CW-1:0] rep_cnt_d [2];
  logic [1:0]    rep_first_q;
  logic [1:0]    rep_first_d;

  // Repeat timers for left/right, restarted by each initial or repeat pulse
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      rep_cnt_d[i]   = rep_cnt_q[i];
      rep_first_d[i] = rep_first_q[i];
      rep_fire_s[i]  = 1'b0;
      if (!stable_q[i]) begin
        rep_cnt_d[i]   = '0;
        rep_first_d[i] = 1'b1;
      end else if (rise_s[i]) begin
        rep_cnt_d[i]   = CW'(1);
        rep_first_d[i] = 1'b1;
      end else if (rep_cnt_q[i] != '0) begin
        if (rep_cnt_q[i] == (rep_first_q[i] ? CW'(REPEAT_DELAY) : CW'(REPEAT_PERIOD))) begin
          rep_fire_s[i]  = 1'b1;
          rep_cnt_d[i]   = CW'(1);
          rep_first_d[i] = 1'b0;
        end else if (rep_cnt_q[i] != {CW{1'b1}}) begin
          rep_cnt_d[i] = rep_cnt_q[i] + CW'(1);
        end else begin
          rep_cnt_d[i] = rep_cnt_q[i];
        end
      end else begin
        rep_cnt_d[i] = rep_cnt_q[i];
      end
    end
  end

  // Repeat timer state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rep_first_q <= 2'b11;
      for (int i = 0; i < 2; i++) rep_cnt_q[i] <= '0;
    end else begin
      rep_first_q <= rep_first_d;
      for (int i = 0; i < 2; i++) rep_cnt_q[i] <= rep_cnt_d[i];
    end
  end
`else
  assign rep_fire_s = 2'b00;
`endif

  assign ev_s = {rise_s[2], rise_s[1] | rep_fire_s[1], rise_s[0] | rep_fire_s[0]};

  // Conflict arbitration: put wins, simultaneous left+right cancel; never high two cycles running
  always_comb begin
    put_d   = ev_s[2] & ~put_q;
    left_d  = ev_s[0] & ~ev_s[1] & ~ev_s[2] & ~left_q;
    right_d = ev_s[1] & ~ev_s[0] & ~ev_s[2] & ~right_q;
  end

  // Registered pulse outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      left_q  <= 1'b0;
      right_q <= 1'b0;
      put_q   <= 1'b0;
    end else begin
      left_q  <= left_d;
      right_q <= right_d;
      put_q   <= put_d;
    end
  end

  assign left  = left_q;
  assign right = right_q;
  assign put   = put_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5.
module tb_button_conditioner;

  logic clk;
  logic rst;
  logic left_raw, right_raw, put_raw;
  logic left, right, put;

  int total;
  int bad;

  logic [63:0] lw_v, rw_v, pw_v;

  button_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .REPEAT_DELAY(10),
    .REPEAT_PERIOD(5)
  ) dut (
    .clk(clk),
    .rst(rst),
    .left_raw(left_raw),
    .right_raw(right_raw),
    .put_raw(put_raw),
    .left(left),
    .right(right),
    .put(put)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst       = 1'b0;
    left_raw  = 1'b0;
    right_raw = 1'b0;
    put_raw   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Raw input i is high before edges E0..E(len-1); bit k of each vector is the output after Ek.
  task automatic capture(input int l_len, input int r_len, input int p_len, input int n);
    lw_v = 64'd0;
    rw_v = 64'd0;
    pw_v = 64'd0;
    for (int k = 0; k < n; k++) begin
      left_raw  = (k < l_len);
      right_raw = (k < r_len);
      put_raw   = (k < p_len);
      @(posedge clk);
      #1;
      lw_v[k] = left;
      rw_v[k] = right;
      pw_v[k] = put;
    end
    left_raw  = 1'b0;
    right_raw = 1'b0;
    put_raw   = 1'b0;
  endtask

  task automatic check_vec(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic test_reset();
    logic [2:0] o;
    rst = 1'b0;
    left_raw = 1'b1;
    right_raw = 1'b0;
    put_raw = 1'b1;
    o = 3'b000;
    repeat (8) begin
      @(posedge clk);
      #1;
      o = o | {left, right, put};
    end
    total++;
    if (o !== 3'b000) begin
      bad++;
      $display("FAIL reset_outputs: got=%b expected=000", o);
    end
    put_raw = 1'b0;
    rst = 1'b1;
    capture(30, 0, 0, 30);
    check_vec("held_through_reset_left", lw_v, 64'd1 << 6);
    check_vec("held_through_reset_put", pw_v, 64'd0);
  endtask

  task automatic test_single_press();
    do_reset();
    capture(0, 0, 20, 40);
    check_vec("single_put", pw_v, 64'd1 << 6);
    check_vec("single_left", lw_v, 64'd0);
    check_vec("single_right", rw_v, 64'd0);
  endtask

  task automatic test_glitch();
    do_reset();
    capture(3, 0, 0, 30);
    check_vec("glitch_left", lw_v, 64'd0);
    do_reset();
    capture(0, 0, 4, 30);
    check_vec("short_press_put", pw_v, 64'd1 << 6);
  endtask

  task automatic test_lr_conflict();
    do_reset();
    capture(30, 30, 0, 40);
    check_vec("lr_conflict_left", lw_v, 64'd0);
    check_vec("lr_conflict_right", rw_v, 64'd0);
  endtask

  task automatic test_put_priority();
    do_reset();
    capture(8, 0, 8, 30);
    check_vec("put_prio_put", pw_v, 64'd1 << 6);
    check_vec("put_prio_left", lw_v, 64'd0);
  endtask

  task automatic test_repeat();
    logic [63:0] exp;
    do_reset();
    capture(0, 25, 0, 40);
`ifdef BUTTON_AUTO_REPEAT_EN
    exp = (64'd1 << 6) | (64'd1 << 16) | (64'd1 << 21) | (64'd1 << 26);
`else
    exp = 64'd1 << 6;
`endif
    check_vec("repeat_right", rw_v, exp);
    check_vec("repeat_left", lw_v, 64'd0);
  endtask

  task automatic test_reset_mid();
    do_reset();
    lw_v = 64'd0;
    for (int k = 0; k < 30; k++) begin
      left_raw = 1'b1;
      if (k == 3) rst = 1'b0;
      if (k == 10) rst = 1'b1;
      @(posedge clk);
      #1;
      lw_v[k] = left;
    end
    left_raw = 1'b0;
    check_vec("reset_mid_left", lw_v, 64'd1 << 16);
  endtask

  task automatic test_back_to_back();
    do_reset();
    // two presses separated by enough idle time for the level to fall
    lw_v = 64'd0;
    for (int k = 0; k < 40; k++) begin
      left_raw = (k < 8) || (k >= 18 && k < 26);
      @(posedge clk);
      #1;
      lw_v[k] = left;
    end
    left_raw = 1'b0;
    check_vec("back_to_back_left", lw_v, (64'd1 << 6) | (64'd1 << 24));
  endtask

  initial begin
    total = 0;
    bad = 0;
    rst = 1'b0;
    left_raw = 1'b0;
    right_raw = 1'b0;
    put_raw = 1'b0;
    test_reset();
    test_single_press();
    test_glitch();
    test_lr_conflict();
    test_put_priority();
    test_repeat();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000: consecutive synchronized samples required to accept a level change (minimum 2).
REQ-002 SHALL have parameter REPEAT_DELAY, default 25000000: cycles from the initial pulse to the first auto-repeat pulse.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10000000: cycles between subsequent auto-repeat pulses.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports left_raw, right_raw, put_raw  input  1 each  asynchronous, bouncy, active-high pushbuttons.
REQ-007 SHALL have ports left, right, put  output  1 each  registered single-cycle press pulses, consumed directly by the game FSM and state-update logic.

Function
REQ-008 SHALL pass each raw input through its own 2-flop synchronizer; no raw input reaches any other logic.
REQ-009 SHALL keep per button a debounced level (stable) and a mismatch counter; the counter increments on each edge where the synchronized value differs from stable, and clears on any edge where they match.
REQ-010 SHALL flip stable on the DEBOUNCE_CYCLES-th consecutive mismatch edge and clear the counter on that same edge.
REQ-011 SHALL raise the button's raw pulse on the stable 0->1 transition only; a 1->0 transition produces no pulse.
REQ-012 Latency: with raw held high and first sampled at edge E0, the output pulse SHALL be high for exactly the one cycle following edge E(DEBOUNCE_CYCLES+2).
REQ-013 SHALL produce no pulse for any high glitch shorter than DEBOUNCE_CYCLES synchronized samples, and no extra pulse for release bounce.
REQ-014 Conflict rule 1: left and right pulses falling in the same cycle SHALL both be suppressed.
REQ-015 Conflict rule 2: put coinciding with left or right SHALL be emitted, and the left/right pulse SHALL be dropped.
REQ-016 SHALL never hold any output high for two consecutive cycles.
REQ-017 Counter width SHALL be $clog2 of the largest parameter plus 1; counters saturate, never wrap.

Reset
REQ-018 On rst low, SHALL immediately clear all synchronizer flops, stable levels, counters and repeat timers; left, right and put SHALL read 0.
REQ-019 Reset mid-debounce or mid-repeat SHALL discard all progress.
REQ-020 A button held through reset release SHALL produce one pulse at the REQ-012 latency, measured from the first edge after release.

Configuration
REQ-021 Macro BUTTON_AUTO_REPEAT_EN SHALL control auto-repeat for left and right.
REQ-022 With BUTTON_AUTO_REPEAT_EN defined, while stable stays high:
- one extra pulse SHALL issue REPEAT_DELAY edges after the initial pulse edge;
- further pulses SHALL follow every REPEAT_PERIOD edges;
- stable going low SHALL clear the repeat timer immediately;
- put SHALL never repeat.
REQ-023 Without BUTTON_AUTO_REPEAT_EN, SHALL emit exactly one pulse per press; no repeat timers SHALL be synthesized.
REQ-024 Repeat pulses SHALL be subject to REQ-014 and REQ-015.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=5)
REQ-025 Stimulus: put_raw high from E0 for 20 cycles -> put high only in the cycle after E6; exactly one pulse.
REQ-026 Stimulus: left_raw high for 3 cycles, then low -> left never asserts.
REQ-027 Stimulus: left_raw and right_raw rise together and are held -> left and right stay 0.
REQ-028 Stimulus: put_raw and left_raw rise together -> put pulses after E6; left stays 0.
REQ-029 Stimulus: right_raw high from E0, low from E25 -> with BUTTON_AUTO_REPEAT_EN, pulses after E6, E16, E21 and E26 and none after E30; without the macro, only the pulse after E6.
REQ-030 Stimulus: left_raw held, rst asserted at E3 and released before E10 (first edge after release = E10) -> no pulse before release; one pulse after E16.
